// File: rtl/dec2bin_rx.sv
// ASCII decimal line parser: accumulates digits into a 14-bit value (x10 per digit)
// and emits one result per CR/LF-terminated line, with overflow and bad-char flags.
module dec2bin_rx #(
  parameter int MAX_DIGITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [13:0] value,
  output logic        value_valid,
  output logic        err_overflow,
  output logic        err_char,
  output logic [3:0]  digit_count
);

  typedef enum logic [2:0] {IDLE, ACC, MUL, SKIP, EMIT} state_t;

  localparam logic [3:0]  MAXD = 4'(MAX_DIGITS);
  localparam logic [18:0] VMAX = 19'd16383;

  state_t      state, state_nxt;
  logic [13:0] acc;
  logic [3:0]  cnt, d, cnt_inc;
  logic        ovf, err;
  logic        accept, is_digit, is_term;
  logic [18:0] acc_next;

  assign rx_ready = (state == IDLE) || (state == ACC) || (state == SKIP);
  assign accept   = rx_valid && rx_ready;
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term  = (rx_data == 8'h0d) || (rx_data == 8'h0a);
  assign acc_next = ({5'b0, acc} << 3) + ({5'b0, acc} << 1) + {15'b0, d};
  assign cnt_inc  = (cnt == 4'hf) ? cnt : cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC:
        if (accept) begin
          if (is_digit)              state_nxt = MUL;
          else if (is_term)          state_nxt = (state == IDLE) ? IDLE : EMIT;
          else                       state_nxt = SKIP;
        end
      MUL:  state_nxt = ACC;
      SKIP: if (accept && is_term) state_nxt = EMIT;
      EMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are registered on the terminator edge so they are visible during EMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      cnt          <= '0;
      d            <= '0;
      ovf          <= 1'b0;
      err          <= 1'b0;
      value        <= '0;
      value_valid  <= 1'b0;
      err_overflow <= 1'b0;
      err_char     <= 1'b0;
      digit_count  <= '0;
    end else begin
      value_valid <= 1'b0;
      if (accept && is_term && state != IDLE) begin
        value        <= err ? 14'd0 : acc;
        err_overflow <= ovf & ~err;
        err_char     <= err;
        digit_count  <= cnt;
        value_valid  <= 1'b1;
        acc          <= '0;
        cnt          <= '0;
        ovf          <= 1'b0;
        err          <= 1'b0;
      end else if (accept && (state == IDLE || state == ACC)) begin
        if (is_digit)     d   <= rx_data[3:0];
        else if (!is_term) err <= 1'b1;
      end
      if (state == MUL) begin
        acc <= (acc_next > VMAX) ? 14'h3fff : acc_next[13:0];
        cnt <= cnt_inc;
        if (acc_next > VMAX || cnt_inc > MAXD) ovf <= 1'b1;
      end
    end
  end

endmodule
